// File: rtl/dm_wait_responder.sv
// dm_wait_responder: data-memory responder with programmable wait states, byte-lane writes and registered read data.
// Define DM_PARITY_EN to add per-byte even-parity storage and a read-side parity_err flag.
module dm_wait_responder #(
   parameter int ADDR_W      = 14,
   parameter int WAIT_CYCLES = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              CS,
   input  logic              OE,
   input  logic [3:0]        WEB,
   input  logic [ADDR_W-1:0] A,
   input  logic [31:0]       DI,
   output logic [31:0]       DO,
   output logic              stall,
   output logic              parity_err
);

   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   logic [31:0]       mem [DEPTH];
   logic              wr_req;
   logic              rd_req;
   logic              acc_wr;
   logic              acc_rd;
   logic [ADDR_W-1:0] acc_a;
   logic [3:0]        acc_web;
   logic [31:0]       acc_di;

   // Handshake: the initiator presents a request and holds it stable while stall=1; the request
   // completes in the first cycle it is seen with stall=0, and the initiator may advance after that edge.
   assign wr_req = CS && (WEB != 4'hF);
   assign rd_req = CS && OE && (WEB == 4'hF);

   generate
      if (WAIT_CYCLES == 0) begin : g_direct
         assign stall   = 1'b0;
         assign acc_wr  = wr_req;
         assign acc_rd  = rd_req;
         assign acc_a   = A;
         assign acc_web = WEB;
         assign acc_di  = DI;
      end else begin : g_wait
         state_t            state;
         state_t            state_nxt;
         logic [3:0]        cnt;
         logic [3:0]        cnt_nxt;
         logic              lat_wr;
         logic              lat_wr_nxt;
         logic [ADDR_W-1:0] lat_a;
         logic [ADDR_W-1:0] lat_a_nxt;
         logic [3:0]        lat_web;
         logic [3:0]        lat_web_nxt;
         logic [31:0]       lat_di;
         logic [31:0]       lat_di_nxt;

         always_ff @(posedge clk) begin
            if (rst) begin
               state   <= IDLE;
               cnt     <= 4'd0;
               lat_wr  <= 1'b0;
               lat_a   <= '0;
               lat_web <= 4'hF;
               lat_di  <= '0;
            end else begin
               state   <= state_nxt;
               cnt     <= cnt_nxt;
               lat_wr  <= lat_wr_nxt;
               lat_a   <= lat_a_nxt;
               lat_web <= lat_web_nxt;
               lat_di  <= lat_di_nxt;
            end
         end

         always_comb begin
            state_nxt   = state;
            cnt_nxt     = cnt;
            lat_wr_nxt  = lat_wr;
            lat_a_nxt   = lat_a;
            lat_web_nxt = lat_web;
            lat_di_nxt  = lat_di;
            stall       = 1'b0;
            acc_wr      = 1'b0;
            acc_rd      = 1'b0;
            case (state)
               IDLE: begin
                  if (wr_req || rd_req) begin
                     stall       = 1'b1;
                     lat_wr_nxt  = wr_req;
                     lat_a_nxt   = A;
                     lat_web_nxt = WEB;
                     lat_di_nxt  = DI;
                     cnt_nxt     = 4'(WAIT_CYCLES - 1);
                     state_nxt   = BUSY;
                  end
               end
               BUSY: begin
                  stall = 1'b1;
                  if (cnt != 4'd0) begin
                     cnt_nxt = cnt - 4'd1;
                  end else begin
                     acc_wr    = lat_wr;
                     acc_rd    = !lat_wr;
                     state_nxt = DONE;
                  end
               end
               // Inputs still show the request just completed; ignore them.
               DONE:    state_nxt = IDLE;
               default: state_nxt = IDLE;
            endcase
         end

         assign acc_a   = lat_a;
         assign acc_web = lat_web;
         assign acc_di  = lat_di;
      end
   endgenerate

   // A reset edge never commits a write, even one in flight.
   always_ff @(posedge clk) begin
      if (!rst && acc_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (!acc_web[i]) mem[acc_a][8*i +: 8] <= acc_di[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         DO <= '0;
      end else if (acc_rd) begin
         DO <= mem[acc_a];
      end
   end

`ifdef DM_PARITY_EN
   logic       par_mem [DEPTH][4];
   logic [3:0] par_mismatch;

   always_ff @(posedge clk) begin
      if (!rst && acc_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (!acc_web[i]) par_mem[acc_a][i] <= ^acc_di[8*i +: 8];
         end
      end
   end

   always_comb begin
      par_mismatch = 4'd0;
      for (int i = 0; i < 4; i++) begin
         par_mismatch[i] = par_mem[acc_a][i] ^ (^mem[acc_a][8*i +: 8]);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         parity_err <= 1'b0;
      end else if (acc_rd) begin
         parity_err <= |par_mismatch;
      end
   end
`else
   assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_dm_wait_responder.sv
// Directed bench for dm_wait_responder: three instances (0, 2 and 3 wait states) share one request bus.
module tb_dm_wait_responder;
   localparam int AW = 14;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cs  = 1'b0;
   logic          oe  = 1'b0;
   logic [3:0]    web = 4'hF;
   logic [AW-1:0] a   = '0;
   logic [31:0]   di  = '0;
   logic [31:0]   do0, do2, do3;
   logic          st0, st2, st3;
   logic          pe0, pe2, pe3;
   int            total    = 0;
   int            bad      = 0;
   int            st0_high = 0;
   logic [31:0]   exp_q[$];

   always #5 clk = ~clk;

   dm_wait_responder #(.ADDR_W(AW), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .rst(rst), .CS(cs), .OE(oe), .WEB(web), .A(a), .DI(di),
      .DO(do0), .stall(st0), .parity_err(pe0));
   dm_wait_responder #(.ADDR_W(AW), .WAIT_CYCLES(2)) u_dut2 (
      .clk(clk), .rst(rst), .CS(cs), .OE(oe), .WEB(web), .A(a), .DI(di),
      .DO(do2), .stall(st2), .parity_err(pe2));
   dm_wait_responder #(.ADDR_W(AW), .WAIT_CYCLES(3)) u_dut3 (
      .clk(clk), .rst(rst), .CS(cs), .OE(oe), .WEB(web), .A(a), .DI(di),
      .DO(do3), .stall(st3), .parity_err(pe3));

   always @(posedge clk) if (st0 !== 1'b0) st0_high++;

   function automatic logic stall_of(input int sel);
      return (sel == 3) ? st3 : st2;
   endfunction

   task automatic drive(input logic c, input logic o, input logic [3:0] w,
                        input logic [AW-1:0] ad, input logic [31:0] d);
      @(negedge clk);
      cs = c; oe = o; web = w; a = ad; di = d;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1; cs = 1'b0; oe = 1'b0; web = 4'hF;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Counts stall cycles from the request cycle; returns in the DONE cycle (or at the budget).
   task automatic wait_done(input int sel, output int n);
      n = 0;
      #1;
      while (stall_of(sel) && n < 40) begin
         n++;
         @(negedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++; if (do0 !== 32'h0) begin bad++; $display("FAIL reset_do0 got=%h exp=%h", do0, 32'h0); end
      total++; if (do2 !== 32'h0) begin bad++; $display("FAIL reset_do2 got=%h exp=%h", do2, 32'h0); end
      total++; if (do3 !== 32'h0) begin bad++; $display("FAIL reset_do3 got=%h exp=%h", do3, 32'h0); end
      total++; if (pe0 !== 1'b0) begin bad++; $display("FAIL reset_pe0 got=%b exp=0", pe0); end
      rst = 1'b0;
      #1;
      total++; if (st2 !== 1'b0) begin bad++; $display("FAIL reset_st2 got=%b exp=0", st2); end
      total++; if (st3 !== 1'b0) begin bad++; $display("FAIL reset_st3 got=%b exp=0", st3); end
   endtask

   task automatic test_n0_write_read();
      drive(1'b1, 1'b0, 4'h0, 14'd5, 32'hDEADBEEF);
      @(posedge clk); #1;
      total++; if (do0 !== 32'h0) begin bad++; $display("FAIL n0_write_do got=%h exp=%h", do0, 32'h0); end
      drive(1'b1, 1'b1, 4'hF, 14'd5, 32'h0);
      @(posedge clk); #1;
      total++; if (do0 !== 32'hDEADBEEF) begin bad++; $display("FAIL n0_read5 got=%h exp=%h", do0, 32'hDEADBEEF); end
      total++; if (pe0 !== 1'b0) begin bad++; $display("FAIL n0_read5_pe got=%b exp=0", pe0); end
      drive(1'b1, 1'b1, 4'h0, 14'd5, 32'h01020304);
      @(posedge clk); #1;
      total++; if (do0 !== 32'hDEADBEEF) begin bad++; $display("FAIL n0_wr_prio_do got=%h exp=%h", do0, 32'hDEADBEEF); end
      drive(1'b1, 1'b1, 4'hF, 14'd5, 32'h0);
      @(posedge clk); #1;
      total++; if (do0 !== 32'h01020304) begin bad++; $display("FAIL n0_wr_prio_read got=%h exp=%h", do0, 32'h01020304); end
   endtask

   task automatic test_n0_byte_lane();
      drive(1'b1, 1'b0, 4'h0, 14'd7, 32'h11223344);
      drive(1'b1, 1'b0, 4'b1101, 14'd7, 32'hAABBCCDD);
      drive(1'b1, 1'b1, 4'hF, 14'd7, 32'h0);
      @(posedge clk); #1;
      total++; if (do0 !== 32'h1122CC44) begin bad++; $display("FAIL n0_lane1 got=%h exp=%h", do0, 32'h1122CC44); end
      drive(1'b1, 1'b0, 4'b0110, 14'd7, 32'h55667788);
      drive(1'b1, 1'b1, 4'hF, 14'd7, 32'h0);
      @(posedge clk); #1;
      total++; if (do0 !== 32'h5522CC88) begin bad++; $display("FAIL n0_lane03 got=%h exp=%h", do0, 32'h5522CC88); end
   endtask

   task automatic test_n0_idle_hold();
      drive(1'b0, 1'b1, 4'hF, 14'd5, 32'h0);
      @(posedge clk); #1;
      total++; if (do0 !== 32'h5522CC88) begin bad++; $display("FAIL n0_cs0_hold got=%h exp=%h", do0, 32'h5522CC88); end
      drive(1'b1, 1'b0, 4'hF, 14'd5, 32'h0);
      @(posedge clk); #1;
      total++; if (do0 !== 32'h5522CC88) begin bad++; $display("FAIL n0_oe0_hold got=%h exp=%h", do0, 32'h5522CC88); end
      drive(1'b0, 1'b0, 4'h0, 14'd7, 32'hFFFFFFFF);
      drive(1'b1, 1'b1, 4'hF, 14'd7, 32'h0);
      @(posedge clk); #1;
      total++; if (do0 !== 32'h5522CC88) begin bad++; $display("FAIL n0_cs0_nowrite got=%h exp=%h", do0, 32'h5522CC88); end
   endtask

   task automatic test_wait_read();
      int n;
      apply_reset();
      drive(1'b1, 1'b0, 4'h0, 14'd3, 32'h0000CAFE);
      wait_done(2, n);
      total++; if (n !== 3) begin bad++; $display("FAIL n2_write_stall got=%0d exp=3", n); end
      drive(1'b1, 1'b1, 4'hF, 14'd3, 32'h0);
      wait_done(2, n);
      total++; if (n !== 3) begin bad++; $display("FAIL n2_read_stall got=%0d exp=3", n); end
      total++; if (do2 !== 32'h0000CAFE) begin bad++; $display("FAIL n2_read_do got=%h exp=%h", do2, 32'h0000CAFE); end
      // Request stays held across the DONE edge; it must not be taken again.
      drive(1'b0, 1'b0, 4'hF, 14'd0, 32'h0);
      #1;
      total++; if (st2 !== 1'b0) begin bad++; $display("FAIL n2_done_ignore got=%b exp=0", st2); end
      @(negedge clk); #1;
      total++; if (st2 !== 1'b0) begin bad++; $display("FAIL n2_cs0_stall got=%b exp=0", st2); end
      total++; if (do2 !== 32'h0000CAFE) begin bad++; $display("FAIL n2_cs0_hold got=%h exp=%h", do2, 32'h0000CAFE); end
      drive(1'b1, 1'b0, 4'hF, 14'd3, 32'h0);
      #1;
      total++; if (st2 !== 1'b0) begin bad++; $display("FAIL n2_oe0_stall got=%b exp=0", st2); end
      @(posedge clk); #1;
      total++; if (do2 !== 32'h0000CAFE) begin bad++; $display("FAIL n2_oe0_hold got=%h exp=%h", do2, 32'h0000CAFE); end
   endtask

   task automatic test_wait_reset();
      int n;
      apply_reset();
      drive(1'b1, 1'b0, 4'h0, 14'd9, 32'h0BADF00D);
      wait_done(3, n);
      total++; if (n !== 4) begin bad++; $display("FAIL n3_write_stall got=%0d exp=4", n); end
      drive(1'b1, 1'b1, 4'hF, 14'd9, 32'h0);
      wait_done(3, n);
      total++; if (do3 !== 32'h0BADF00D) begin bad++; $display("FAIL n3_preload got=%h exp=%h", do3, 32'h0BADF00D); end
      drive(1'b1, 1'b0, 4'h0, 14'd9, 32'h12345678);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1; cs = 1'b0; web = 4'hF;
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++; if (st3 !== 1'b0) begin bad++; $display("FAIL n3_rst_stall got=%b exp=0", st3); end
      total++; if (do3 !== 32'h0) begin bad++; $display("FAIL n3_rst_do got=%h exp=%h", do3, 32'h0); end
      drive(1'b1, 1'b1, 4'hF, 14'd9, 32'h0);
      wait_done(3, n);
      total++; if (n !== 4) begin bad++; $display("FAIL n3_read_stall got=%0d exp=4", n); end
      total++; if (do3 !== 32'h0BADF00D) begin bad++; $display("FAIL n3_abort_mem got=%h exp=%h", do3, 32'h0BADF00D); end
   endtask

   task automatic test_back_to_back();
      int          n;
      logic        op_wr [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      logic [3:0]  op_web[6] = '{4'h0, 4'h0, 4'hF, 4'hF, 4'b1110, 4'hF};
      logic [13:0] op_a  [6] = '{14'd20, 14'd21, 14'd20, 14'd21, 14'd20, 14'd20};
      logic [31:0] op_di [6] = '{32'hA5A50001, 32'h5A5A0002, 32'h0, 32'h0, 32'hFFFFFF77, 32'h0};
      logic [31:0] op_exp[6] = '{32'h0, 32'h0, 32'hA5A50001, 32'h5A5A0002, 32'h0, 32'hA5A50077};
      logic [31:0] exp_v;
      apply_reset();
      for (int i = 0; i < 6; i++) begin
         if (!op_wr[i]) exp_q.push_back(op_exp[i]);
         drive(1'b1, !op_wr[i], op_web[i], op_a[i], op_di[i]);
         wait_done(2, n);
         total++; if (n !== 3) begin bad++; $display("FAIL b2b_stall_%0d got=%0d exp=3", i, n); end
         if (!op_wr[i]) begin
            exp_v = exp_q.pop_front();
            total++; if (do2 !== exp_v) begin bad++; $display("FAIL b2b_read_%0d got=%h exp=%h", i, do2, exp_v); end
         end
      end
      drive(1'b0, 1'b0, 4'hF, 14'd0, 32'h0);
   endtask

`ifdef DM_PARITY_EN
   task automatic test_parity();
      apply_reset();
      drive(1'b1, 1'b0, 4'h0, 14'd1, 32'h01234567);
      drive(1'b1, 1'b0, 4'h0, 14'd2, 32'h89ABCDEF);
      @(negedge clk);
      cs = 1'b0; web = 4'hF;
      u_dut0.par_mem[1][0] = ~u_dut0.par_mem[1][0];
      drive(1'b1, 1'b1, 4'hF, 14'd1, 32'h0);
      @(posedge clk); #1;
      total++; if (pe0 !== 1'b1) begin bad++; $display("FAIL par_err_set got=%b exp=1", pe0); end
      total++; if (do0 !== 32'h01234567) begin bad++; $display("FAIL par_err_do got=%h exp=%h", do0, 32'h01234567); end
      drive(1'b1, 1'b1, 4'hF, 14'd2, 32'h0);
      @(posedge clk); #1;
      total++; if (pe0 !== 1'b0) begin bad++; $display("FAIL par_err_clear got=%b exp=0", pe0); end
      drive(1'b0, 1'b0, 4'hF, 14'd0, 32'h0);
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL sim_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_n0_write_read();
      test_n0_byte_lane();
      test_n0_idle_hold();
      test_wait_read();
      test_wait_reset();
      test_back_to_back();
`ifdef DM_PARITY_EN
      test_parity();
`endif
      @(negedge clk);
      total++; if (st0_high !== 0) begin bad++; $display("FAIL n0_stall_never got=%0d exp=0", st0_high); end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
